// File: rtl/inbuf_vc_port.sv
// inbuf_vc_port: link-side input buffer for one router port with two
// virtual channels. The link VC (= polarity) accepts from upstream while the
// internal VC (= ~polarity) presents its head packet to the crossbar as a
// one-hot request with the active hop field pre-decremented.
// Optional build macro: INBUF_VC_CHECK_EN -- drops packets whose vc bit
// (di[63]) disagrees with the link phase and pulses err the next cycle.
module inbuf_vc_port #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          polarity,
  input  logic          si,
  output logic          ri,
  input  logic [PW-1:0] di,
  output logic [4:0]    req,
  input  logic          gnt,
  output logic [PW-1:0] dout,
  output logic [1:0]    vc_full,
  output logic [1:0]    vc_empty,
  output logic          err
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Packet field positions
  localparam int unsigned VC_B  = 63;
  localparam int unsigned XS_B  = 62;
  localparam int unsigned YS_B  = 61;
  localparam int unsigned HX_LO = 52;
  localparam int unsigned HY_LO = 48;

  logic [PW-1:0]    mem_q   [2][DEPTH];
  logic [PW-1:0]    mem_d   [2][DEPTH];
  logic [PTR_W-1:0] wptr_q  [2];
  logic [PTR_W-1:0] wptr_d  [2];
  logic [PTR_W-1:0] rptr_q  [2];
  logic [PTR_W-1:0] rptr_d  [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  logic             lnk_vc;
  logic             int_vc;
  logic             accept;
  logic             wr_en;
  logic             pop;
  logic [PW-1:0]    head;
  logic [3:0]       hx;
  logic [3:0]       hy;

  // Wrapping pointer increment, valid for any DEPTH
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign lnk_vc = polarity;
  assign int_vc = ~polarity;

  // Per-VC occupancy flags and link-side handshake
  always_comb begin
    for (int v = 0; v < 2; v++) begin
      vc_full[v]  = (cnt_q[v] == CNT_W'(DEPTH));
      vc_empty[v] = (cnt_q[v] == '0);
    end
    ri     = ~vc_full[lnk_vc];
    accept = si & ri;
  end

`ifdef INBUF_VC_CHECK_EN
  logic err_q;
  logic err_d;

  // Only packets tagged for the current link VC are stored
  always_comb begin
    wr_en = accept & (di[VC_B] == polarity);
    err_d = accept & (di[VC_B] != polarity);
  end

  // Registered one-cycle error pulse
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign wr_en = accept;
  assign err   = 1'b0;
`endif

  // Head-of-line routing: x hops first, then y, then local PE
  always_comb begin
    head = mem_q[int_vc][rptr_q[int_vc]];
    hx   = head[HX_LO +: 4];
    hy   = head[HY_LO +: 4];
    req  = '0;
    dout = '0;
    if (!vc_empty[int_vc]) begin
      dout = head;
      if (hx != 4'd0) begin
        req                = head[XS_B] ? 5'b00010 : 5'b00001;
        dout[HX_LO +: 4]   = hx - 4'd1;
      end else if (hy != 4'd0) begin
        req                = head[YS_B] ? 5'b01000 : 5'b00100;
        dout[HY_LO +: 4]   = hy - 4'd1;
      end else begin
        req                = 5'b10000;
      end
    end
    pop = gnt & (req != 5'b00000);
  end

  // Next-state for pointers, counts and storage
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr_en) begin
      mem_d[lnk_vc][wptr_q[lnk_vc]] = di;
      wptr_d[lnk_vc] = ptr_inc(wptr_q[lnk_vc]);
      cnt_d[lnk_vc]  = cnt_q[lnk_vc] + CNT_W'(1);
    end
    if (pop) begin
      rptr_d[int_vc] = ptr_inc(rptr_q[int_vc]);
      cnt_d[int_vc]  = cnt_q[int_vc] - CNT_W'(1);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '{default: '0};
      rptr_q <= '{default: '0};
      cnt_q  <= '{default: '0};
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Packet storage; contents are meaningless while the count is zero
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_inbuf_vc_port.sv
// Testbench for inbuf_vc_port: a queue-per-VC reference model predicts every
// cycle's outputs; predictions are queued by the stimulus process and checked
// by an independent monitor.
module tb_inbuf_vc_port;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PW    = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          polarity = 1'b1;
  logic          si = 1'b0;
  logic          ri;
  logic [PW-1:0] di = '0;
  logic [4:0]    req;
  logic          gnt = 1'b0;
  logic [PW-1:0] dout;
  logic [1:0]    vc_full;
  logic [1:0]    vc_empty;
  logic          err;

  inbuf_vc_port #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .si       (si),
    .ri       (ri),
    .di       (di),
    .req      (req),
    .gnt      (gnt),
    .dout     (dout),
    .vc_full  (vc_full),
    .vc_empty (vc_empty),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        ri;
    logic [4:0]  req;
    logic [63:0] dout;
    logic [1:0]  full;
    logic [1:0]  empty;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mq0[$];
  logic [63:0] mq1[$];
  logic        model_valid = 1'b0;
  logic        err_pend = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Routing rule: hop x first, then y, else deliver to PE
  function automatic void route(input logic [63:0] p, output logic [4:0] r,
                                output logic [63:0] d);
    d = p;
    if (p[55:52] != 4'd0) begin
      r = p[62] ? 5'b00010 : 5'b00001;
      d[55:52] = p[55:52] - 4'd1;
    end else if (p[51:48] != 4'd0) begin
      r = p[61] ? 5'b01000 : 5'b00100;
      d[51:48] = p[51:48] - 4'd1;
    end else begin
      r = 5'b10000;
    end
  endfunction

  function automatic logic [63:0] mkpkt(input logic vc, input logic xs, input logic ys,
                                        input logic [3:0] hx, input logic [3:0] hy,
                                        input logic [47:0] pay);
    return {vc, xs, ys, 5'd0, hx, hy, pay};
  endfunction

  // One cycle: drive inputs on the falling edge, predict outputs, advance model
  task automatic step(input logic rst, input logic s, input logic [63:0] d, input logic g);
    exp_t        e;
    logic        l;
    int          n0, n1, nl, ni;
    logic        acc;
    logic        ok;
    @(negedge clk);
    polarity = ~polarity;
    reset    = rst;
    si       = s;
    di       = d;
    gnt      = g;
    l  = polarity;
    n0 = mq0.size();
    n1 = mq1.size();
    nl = l ? n1 : n0;
    ni = l ? n0 : n1;
    e.valid = model_valid;
    e.ri    = (nl < DEPTH);
    e.full  = {n1 == DEPTH, n0 == DEPTH};
    e.empty = {n1 == 0, n0 == 0};
    e.err   = err_pend;
    if (ni == 0) begin
      e.req  = 5'b00000;
      e.dout = '0;
    end else begin
      route(l ? mq0[0] : mq1[0], e.req, e.dout);
    end
    sb.push_back(e);
    if (rst) begin
      mq0.delete();
      mq1.delete();
      err_pend    = 1'b0;
      model_valid = 1'b1;
    end else begin
      acc = s & e.ri;
`ifdef INBUF_VC_CHECK_EN
      ok       = (d[63] == l);
      err_pend = acc & ~ok;
`else
      ok       = 1'b1;
      err_pend = 1'b0;
`endif
      if (acc && ok) begin
        if (l) mq1.push_back(d);
        else   mq0.push_back(d);
      end
      if (g && e.req != 5'b00000) begin
        if (l) void'(mq0.pop_front());
        else   void'(mq1.pop_front());
      end
    end
  endtask

  task automatic idle(input logic g);
    step(1'b0, 1'b0, '0, g);
  endtask

  // Offer a packet on the next cycle whose link VC is vc
  task automatic send(input logic vc, input logic [63:0] p, input logic g);
    if (polarity == vc) idle(g);
    step(1'b0, 1'b1, p, g);
  endtask

  // Monitor: compare DUT against the queued prediction every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow actual=empty expected=entry t=%0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.valid) begin
          chk("ri", 64'(ri), 64'(e.ri));
          chk("req", 64'(req), 64'(e.req));
          chk("dout", dout, e.dout);
          chk("vc_full", 64'(vc_full), 64'(e.full));
          chk("vc_empty", 64'(vc_empty), 64'(e.empty));
          chk("err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0] p;
    logic        r, s, g;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (4) idle(1'b0);

    // East hop then grant
    send(1'b0, mkpkt(1'b0, 1'b0, 1'b0, 4'd3, 4'd1, 48'h1111), 1'b0);
    idle(1'b1);
    idle(1'b0);
    // South hop, then PE delivery
    send(1'b0, mkpkt(1'b0, 1'b0, 1'b1, 4'd0, 4'd2, 48'h2222), 1'b0);
    idle(1'b1);
    send(1'b0, mkpkt(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 48'h3333), 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill VC1 past capacity, VC0 still accepts, then drain in order
    send(1'b1, mkpkt(1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 48'hA1), 1'b0);
    send(1'b1, mkpkt(1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 48'hA2), 1'b0);
    send(1'b1, mkpkt(1'b1, 1'b0, 1'b1, 4'd2, 4'd2, 48'hA3), 1'b0);
    send(1'b0, mkpkt(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 48'hB1), 1'b0);
    repeat (8) idle(1'b1);
    send(1'b1, mkpkt(1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 48'hA4), 1'b1);
    repeat (4) idle(1'b1);

    // Reset while both VCs hold a packet
    send(1'b0, mkpkt(1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 48'hC0), 1'b0);
    send(1'b1, mkpkt(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 48'hC1), 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (3) idle(1'b0);

    // VC tag disagrees with link phase
    send(1'b0, mkpkt(1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 48'hD0), 1'b0);
    repeat (4) idle(1'b1);

    // Randomized traffic with occasional reset and mistagged packets
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 2) != 0);
      g = ($urandom_range(0, 1) != 0);
      p = {$urandom(), $urandom()};
      p[63]    = ($urandom_range(0, 7) == 0) ? polarity : ~polarity;
      p[55:52] = 4'($urandom_range(0, 3));
      p[51:48] = 4'($urandom_range(0, 3));
      step(r, s, p, g);
    end
    repeat (6) idle(1'b1);

    #4;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
